uart_rx_controller: RTL
=======================

# uart_rx_controller

Frame-level sequencer for the UART receive path. Synchronises the serial line, detects and qualifies the start bit, and times mid-bit sampling from a clock-cycle counter. Shifts in 8 data bits LSB first, checks the stop bit, and presents each good byte on a valid/ready handshake. It sits between the pad-side `i_RX` line and the byte consumer, such as a FIFO or register file, and replaces free-running per-clock bit capture with baud-timed sampling.

## Interface
- `CLKS_PER_BIT`, 16, i_CLK cycles per serial bit; legal range 4..65535.
- `i_CLK`  input  1  system clock; every register is clocked on its rising edge.
- `i_RST`  input  1  reset. One clock; reset is synchronous and active-high.
- `i_RX`  input  1  asynchronous serial line; idle high.
- `i_READY`  input  1  consumer accepts `o_DATA` in any cycle where `o_VALID` and `i_READY` are both high.
- `o_DATA`  output  8  last good received byte; held stable while `o_VALID` is high.
- `o_VALID`  output  1  `o_DATA` holds an unconsumed byte.
- `o_BUSY`  output  1  high in every state except IDLE.
- `o_FRAME_ERR`  output  1  one-cycle pulse: the stop bit was sampled low.
- `o_OVERRUN`  output  1  one-cycle pulse: a good frame completed while the previous byte was unconsumed.
- `o_PARITY_ERR`  output  1  one-cycle pulse: the parity check failed. Tied 0 when parity is compiled out.

## Operation
- Synchroniser: `i_RX` passes through a 2-flop synchroniser. All decisions use the second flop, `rx_s`. Both flops reset to 1.
- Bit-timer counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Cleared on every state entry.
  - Counts up one per clock.
  - Declares a "sample point" at `CLKS_PER_BIT-1`, then wraps to 0.
- Bit index: 3-bit counter counting 0..7, cleared on entry to DATA.
- States and transitions:
  - IDLE:
    - `rx_s`=0 → START.
  - START:
    - At count `(CLKS_PER_BIT/2)-1`, sample `rx_s`.
    - Sample 0 → DATA, timer cleared.
    - Sample 1 (glitch) → IDLE. No flags raised.
  - DATA:
    - At each sample point, shift `rx_s` into bit [index] of the shift register (LSB first).
    - After index 7 → PARITY if compiled in, else STOP.
  - PARITY (macro only):
    - At the sample point, compare `rx_s` with the even parity of the 8 data bits.
    - → STOP.
  - STOP:
    - At the sample point, if `rx_s`=1 → DELIVER, else → WAIT_IDLE.
  - DELIVER (1 cycle):
    - If `o_VALID`=0, or `i_READY`=1 this cycle: load `o_DATA` and set `o_VALID`.
    - Otherwise: pulse `o_OVERRUN`, discard the new byte, keep the old byte.
    - → IDLE.
  - WAIT_IDLE:
    - Pulse `o_FRAME_ERR` on entry.
    - Remain until `rx_s`=1 (this absorbs a break condition).
    - → IDLE.
- Parity failure:
  - Pulses `o_PARITY_ERR` on leaving PARITY.
  - The frame still goes through STOP.
  - On a good stop the byte is dropped: DELIVER does not load.
- Handshake:
  - `o_VALID` falls the cycle after `o_VALID` and `i_READY` are both high, unless DELIVER reloads it in that same cycle.
  - `o_DATA` changes only on a load.
- Reset, at any time including mid-frame:
  - State forced to IDLE; counters cleared; shift register cleared.
  - `o_DATA`=8'h00.
  - `o_VALID`, `o_BUSY`, `o_FRAME_ERR`, `o_OVERRUN`, `o_PARITY_ERR` all 0.
  - The partial frame is lost.
  - After reset is released, a line still low forces a new START check at once.

## Timing
- Synchroniser latency: 2 clocks from an `i_RX` edge to `rx_s`.
- Start sample: `CLKS_PER_BIT/2` clocks after `rx_s` falls.
- Data bit n sample: (n+1)·CLKS_PER_BIT clocks after the start sample.
- Stop sample: 9·CLKS_PER_BIT clocks after the start sample, or 10·CLKS_PER_BIT with parity.
- `o_VALID` rises 2 clocks after the stop sample point: one clock into DELIVER, one to register.
- Error pulses are exactly 1 clock wide.
- `o_BUSY` rises the clock after `rx_s` falls and falls the clock after DELIVER or WAIT_IDLE exits.
- A new start bit detected in the cycle IDLE is entered is accepted. No dead cycles beyond DELIVER.

## Configuration
- `UART_RX_PARITY_EN`:
  - When defined, a 9th bit (even parity) is expected between data and stop, PARITY is instantiated, and `o_PARITY_ERR` is live.
  - When undefined, frames are 8N1, PARITY does not exist, and `o_PARITY_ERR` is constant 0.

## Test plan
- Reset mid-frame: assert `i_RST` 1 cycle during DATA bit 3 → all outputs 0 next cycle. A following clean 0x3C frame is received correctly.
- Clean frame: CLKS_PER_BIT=16, send 0xA5 (8N1), `i_READY`=1 → `o_DATA`=0xA5 and a one-cycle `o_VALID`. `o_VALID` rises 2 clocks after the stop sample. No error pulses.
- Glitch rejection: drive `i_RX` low for 5 clocks, then high → no `o_BUSY` beyond START, no `o_VALID`, no flags.
- Framing and break:
  - Send 0x5A with stop=0 → `o_FRAME_ERR` pulses once, `o_VALID` stays 0.
  - Hold the line low a further 40 clocks → `o_BUSY` stays high until the line returns high.
- Overrun and simultaneous accept:
  - `i_READY`=0, send 0x11 then 0x22 → `o_DATA`=0x11 and one `o_OVERRUN` pulse.
  - Repeat with `i_READY` raised exactly in the DELIVER cycle of 0x22 → `o_DATA`=0x22, no `o_OVERRUN`.
- Parity (`UART_RX_PARITY_EN` defined):
  - Send 0x07 with parity=0 → `o_PARITY_ERR` pulse and no `o_VALID`.
  - Send 0x07 with parity=1 → `o_DATA`=0x07.

Source files
------------

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: baud-timed UART receive sequencer.
// A 2-flop synchroniser feeds a frame FSM that qualifies the start bit at
// mid-bit, samples 8 data bits LSB first at each bit-timer sample point,
// checks the stop bit and presents good bytes on a valid/ready output.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data
// and stop; o_PARITY_ERR live). Undefined by default: 8N1 frames.
//
// Handshake: o_DATA/o_VALID form a valid/ready source. A byte transfers on
// every rising i_CLK where o_VALID and i_READY are both high. While o_VALID
// is high o_DATA is held stable; o_VALID never drops without a transfer.
// A byte arriving while the previous one is unconsumed (and not accepted
// in that same cycle) is discarded and reported with an o_OVERRUN pulse.
module uart_rx_controller #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_RX,
    input  logic       i_READY,
    output logic [7:0] o_DATA,
    output logic       o_VALID,
    output logic       o_BUSY,
    output logic       o_FRAME_ERR,
    output logic       o_OVERRUN,
    output logic       o_PARITY_ERR,
    output logic [2:0] o_STATE
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_DELIVER   = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] count;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          parity_bad;
    logic          sample_pt;
    logic          half_pt;
    logic          state_change;
    logic          data_entry;
    logic          load;
    logic          overrun_set;

    assign sample_pt    = (count == SAMPLE_LAST);
    assign half_pt      = (count == HALF_LAST);
    assign state_change = (state_next != state);
    assign data_entry   = (state != S_DATA) && (state_next == S_DATA);

    // A good frame loads when the output slot is free or being emptied now;
    // a parity-failed frame never loads and never counts as an overrun.
    assign load        = (state == S_DELIVER) && !parity_bad && (!o_VALID || i_READY);
    assign overrun_set = (state == S_DELIVER) && !parity_bad && o_VALID && !i_READY;

    assign o_BUSY  = (state != S_IDLE);
    assign o_STATE = state;

    // Two-flop synchroniser on the asynchronous serial line; idles high.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_s    <= rx_meta;
        end
    end

    // Frame state register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start qualified at half-bit, data/stop at sample points.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (half_pt) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample_pt && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_pt) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample_pt) begin
                    state_next = rx_s ? S_DELIVER : S_WAIT_IDLE;
                end
            end
            S_DELIVER: begin
                state_next = S_IDLE;
            end
            S_WAIT_IDLE: begin
                // Stay here through a break until the line returns high.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Bit timer: restarts on every state entry, wraps after each sample point.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            count <= '0;
        end else if (state_change || sample_pt) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Data capture: bit index and shift register, both restarted on DATA entry.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else if (data_entry) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else if ((state == S_DATA) && sample_pt) begin
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict for the current frame; blocks the load in DELIVER.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            parity_bad   <= 1'b0;
            o_PARITY_ERR <= 1'b0;
        end else begin
            o_PARITY_ERR <= 1'b0;
            if (data_entry) begin
                parity_bad <= 1'b0;
            end else if ((state == S_PARITY) && sample_pt) begin
                parity_bad   <= (rx_s != (^shift_reg));
                o_PARITY_ERR <= (rx_s != (^shift_reg));
            end
        end
    end
`else
    // No parity bit on the wire: frames are never rejected for parity.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            parity_bad <= 1'b0;
        end else begin
            parity_bad <= 1'b0;
        end
    end
    assign o_PARITY_ERR = 1'b0;
`endif

    // Output byte slot: load on delivery, release on handshake.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_DATA  <= 8'h00;
            o_VALID <= 1'b0;
        end else if (load) begin
            o_DATA  <= shift_reg;
            o_VALID <= 1'b1;
        end else if (o_VALID && i_READY) begin
            o_VALID <= 1'b0;
        end
    end

    // One-cycle error pulses: framing on WAIT_IDLE entry, overrun after DELIVER.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_FRAME_ERR <= 1'b0;
            o_OVERRUN   <= 1'b0;
        end else begin
            o_FRAME_ERR <= (state == S_STOP) && sample_pt && !rx_s;
            o_OVERRUN   <= overrun_set;
        end
    end

endmodule
